// File: rtl/fifo_pop_ctrl.sv
// Read-side controller for the fifo_4x8 buffer: issues FIFO pops, captures returned words into a
// 2-entry holding buffer and presents them downstream with valid/ready; halts on FIFO error.
module fifo_pop_ctrl #(
    parameter int unsigned DATA_SIZE = 8,
    parameter int unsigned CNT_SIZE  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fifo_empty,
    input  logic                 fifo_error,
    input  logic [DATA_SIZE-1:0] data_out_pop,
    output logic                 read,
    input  logic                 ready_in,
    output logic                 valid_out,
    output logic [DATA_SIZE-1:0] data_out,
    input  logic                 clear_err,
    output logic                 err_latched,
    output logic [CNT_SIZE-1:0]  pop_count
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StErr
    } state_e;

    state_e               state_q, state_d;
    logic [DATA_SIZE-1:0] hold_q [2];
    logic                 wr_ptr_q;
    logic                 rd_ptr_q;
    logic [1:0]           count_q, count_d;
    logic                 inflight_q;
    logic [CNT_SIZE-1:0]  pop_count_q;

    logic                 xfer;
    logic                 capture;
    logic [2:0]           occupancy;
    logic                 room;

    assign xfer      = valid_out & ready_in;
    assign capture   = inflight_q;
    assign occupancy = {1'b0, count_q} + {2'b00, inflight_q};
    // A same-cycle transfer frees a slot, so the limit is relaxed by one when xfer is high.
    assign room      = occupancy < (3'd2 + {2'b00, xfer});

    always_comb begin
        read = (state_q == StRun) & ~fifo_error & ~fifo_empty & room;
    end

    assign valid_out   = (count_q != 2'd0);
    assign data_out    = hold_q[rd_ptr_q];
    assign err_latched = (state_q == StErr);
    assign pop_count   = pop_count_q;

    always_comb begin
        count_d = count_q;
        case ({capture, xfer})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: state_d = StRun;
            StRun: begin
                if (fifo_error) begin
                    state_d = StErr;
                end
            end
            StErr: begin
                // Leave only once nothing is buffered or still on its way back from the FIFO.
                if (clear_err && (count_q == 2'd0) && !inflight_q) begin
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            hold_q[0]   <= '0;
            hold_q[1]   <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            inflight_q  <= 1'b0;
            pop_count_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            inflight_q <= read;
            if (capture) begin
                hold_q[wr_ptr_q] <= data_out_pop;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (xfer) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            if (read) begin
                pop_count_q <= pop_count_q + CNT_SIZE'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_pop_ctrl.sv
// Directed bench for fifo_pop_ctrl with a small behavioural model of the registered-output FIFO.
module tb_fifo_pop_ctrl;

    logic       clk;
    logic       reset;
    logic       fifo_empty;
    logic       fifo_error;
    logic [7:0] data_out_pop;
    logic       read;
    logic       ready_in;
    logic       valid_out;
    logic [7:0] data_out;
    logic       clear_err;
    logic       err_latched;
    logic [7:0] pop_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] fmem [1024];
    int         f_wr = 0;
    int         f_rd = 0;

    fifo_pop_ctrl #(
        .DATA_SIZE(8),
        .CNT_SIZE (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fifo_empty  (fifo_empty),
        .fifo_error  (fifo_error),
        .data_out_pop(data_out_pop),
        .read        (read),
        .ready_in    (ready_in),
        .valid_out   (valid_out),
        .data_out    (data_out),
        .clear_err   (clear_err),
        .err_latched (err_latched),
        .pop_count   (pop_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign fifo_empty = (f_rd == f_wr);

    // FIFO model: data for a pop accepted in cycle N is valid through cycle N+1, garbage otherwise.
    initial data_out_pop = 8'h00;
    always @(posedge clk) begin
        if (read && !fifo_empty) begin
            data_out_pop <= fmem[f_rd];
            f_rd         <= f_rd + 1;
        end else begin
            data_out_pop <= 8'hEE;
        end
    end

    always @(negedge clk) begin
        #2;
        if (reset) begin
            if (read && fifo_empty) begin
                n_fail++;
                $display("FAIL read_while_empty: read=%b fifo_empty=%b", read, fifo_empty);
            end
            if (dut.count_q > 2'd2) begin
                n_fail++;
                $display("FAIL count_range: count=%0d limit=2", dut.count_q);
            end
            if (dut.inflight_q && dut.count_q == 2'd2 && !(valid_out && ready_in)) begin
                n_fail++;
                $display("FAIL capture_full: capture pending with count=2 and no transfer");
            end
        end
    end

    task automatic push(input logic [7:0] w);
        fmem[f_wr] = w;
        f_wr = f_wr + 1;
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        fifo_error = 1'b0;
        ready_in   = 1'b1;
        clear_err  = 1'b0;
        push(8'hA1);
        push(8'hB2);
        push(8'hC3);
        push(8'hD4);
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if (read !== 1'b0) begin
            n_fail++; $display("FAIL reset_read: got %b want 0", read);
        end
        n_tests++;
        if (valid_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b want 0", valid_out);
        end
        n_tests++;
        if (data_out !== 8'h00) begin
            n_fail++; $display("FAIL reset_data: got %h want 00", data_out);
        end
        n_tests++;
        if (err_latched !== 1'b0) begin
            n_fail++; $display("FAIL reset_err: got %b want 0", err_latched);
        end
        n_tests++;
        if (pop_count !== 8'd0) begin
            n_fail++; $display("FAIL reset_pop_count: got %0d want 0", pop_count);
        end
    endtask

    task automatic test_streaming();
        logic [7:0] rd_mask;
        logic [7:0] vld_mask;
        logic [7:0] exp_d [8];
        rd_mask  = 8'b0001_1110;
        vld_mask = 8'b0111_1000;
        foreach (exp_d[i]) exp_d[i] = 8'h00;
        exp_d[3] = 8'hA1;
        exp_d[4] = 8'hB2;
        exp_d[5] = 8'hC3;
        exp_d[6] = 8'hD4;
        @(negedge clk);
        reset    = 1'b1;
        ready_in = 1'b1;
        #1;
        n_tests++;
        if (read !== 1'b0) begin
            n_fail++; $display("FAIL stream_idle_read: got %b want 0", read);
        end
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            #1;
            n_tests++;
            if (read !== rd_mask[k]) begin
                n_fail++; $display("FAIL stream_read[%0d]: got %b want %b", k, read, rd_mask[k]);
            end
            n_tests++;
            if (valid_out !== vld_mask[k]) begin
                n_fail++;
                $display("FAIL stream_valid[%0d]: got %b want %b", k, valid_out, vld_mask[k]);
            end
            if (vld_mask[k]) begin
                n_tests++;
                if (data_out !== exp_d[k]) begin
                    n_fail++;
                    $display("FAIL stream_data[%0d]: got %h want %h", k, data_out, exp_d[k]);
                end
            end
        end
        n_tests++;
        if (pop_count !== 8'd4) begin
            n_fail++; $display("FAIL stream_pop_count: got %0d want 4", pop_count);
        end
    endtask

    task automatic test_backpressure();
        logic [11:0] rd_mask;
        logic [11:0] vld_mask;
        logic [7:0]  exp_d [12];
        rd_mask  = 12'h186;
        vld_mask = 12'h7F8;
        foreach (exp_d[i]) exp_d[i] = 8'hA1;
        exp_d[8]  = 8'hB2;
        exp_d[9]  = 8'hC3;
        exp_d[10] = 8'hD4;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            ready_in = (k >= 7);
            if (k == 1) begin
                push(8'hA1);
                push(8'hB2);
                push(8'hC3);
                push(8'hD4);
            end
            #1;
            n_tests++;
            if (read !== rd_mask[k]) begin
                n_fail++; $display("FAIL bp_read[%0d]: got %b want %b", k, read, rd_mask[k]);
            end
            n_tests++;
            if (valid_out !== vld_mask[k]) begin
                n_fail++; $display("FAIL bp_valid[%0d]: got %b want %b", k, valid_out, vld_mask[k]);
            end
            if (vld_mask[k]) begin
                n_tests++;
                if (data_out !== exp_d[k]) begin
                    n_fail++; $display("FAIL bp_data[%0d]: got %h want %h", k, data_out, exp_d[k]);
                end
            end
            if (k == 6) begin
                n_tests++;
                if (pop_count !== 8'd6) begin
                    n_fail++; $display("FAIL bp_stall_pops: got %0d want 6", pop_count);
                end
            end
        end
        n_tests++;
        if (pop_count !== 8'd8) begin
            n_fail++; $display("FAIL bp_pop_count: got %0d want 8", pop_count);
        end
    endtask

    task automatic test_error();
        @(negedge clk);
        ready_in = 1'b0;
        push(8'h5A);
        push(8'h6B);
        #1;
        n_tests++;
        if (read !== 1'b1) begin
            n_fail++; $display("FAIL err_first_read: got %b want 1", read);
        end
        @(negedge clk);
        fifo_error = 1'b1;
        #1;
        n_tests++;
        if (read !== 1'b0) begin
            n_fail++; $display("FAIL err_priority_read: got %b want 0", read);
        end
        @(negedge clk);
        fifo_error = 1'b0;
        clear_err  = 1'b1;
        #1;
        n_tests++;
        if (err_latched !== 1'b1) begin
            n_fail++; $display("FAIL err_latched: got %b want 1", err_latched);
        end
        n_tests++;
        if (valid_out !== 1'b1 || data_out !== 8'h5A) begin
            n_fail++;
            $display("FAIL err_inflight_word: got valid=%b data=%h want valid=1 data=5a",
                     valid_out, data_out);
        end
        n_tests++;
        if (read !== 1'b0) begin
            n_fail++; $display("FAIL err_read_held: got %b want 0", read);
        end
        @(negedge clk);
        clear_err = 1'b0;
        ready_in  = 1'b1;
        #1;
        n_tests++;
        if (err_latched !== 1'b1 || read !== 1'b0) begin
            n_fail++;
            $display("FAIL err_early_clear: got err=%b read=%b want err=1 read=0",
                     err_latched, read);
        end
        @(negedge clk);
        clear_err = 1'b1;
        #1;
        n_tests++;
        if (valid_out !== 1'b0 || err_latched !== 1'b1 || read !== 1'b0) begin
            n_fail++;
            $display("FAIL err_drained: got valid=%b err=%b read=%b want 0 1 0",
                     valid_out, err_latched, read);
        end
        @(negedge clk);
        clear_err = 1'b0;
        #1;
        n_tests++;
        if (err_latched !== 1'b0 || read !== 1'b1) begin
            n_fail++;
            $display("FAIL err_resume: got err=%b read=%b want err=0 read=1", err_latched, read);
        end
        @(negedge clk);
        @(negedge clk);
        #1;
        n_tests++;
        if (valid_out !== 1'b1 || data_out !== 8'h6B) begin
            n_fail++;
            $display("FAIL err_resume_data: got valid=%b data=%h want 1 6b", valid_out, data_out);
        end
        n_tests++;
        if (pop_count !== 8'd10) begin
            n_fail++; $display("FAIL err_pop_count: got %0d want 10", pop_count);
        end
    endtask

    task automatic test_counter_wrap();
        bit found;
        found = 1'b0;
        ready_in = 1'b1;
        for (int i = 0; i < 247; i++) push(8'(i));
        for (int c = 0; c < 400 && !found; c++) begin
            @(negedge clk);
            #1;
            if (pop_count === 8'd255) found = 1'b1;
        end
        n_tests++;
        if (!found) begin
            n_fail++; $display("FAIL wrap_reach_255: got %0d want 255 within 400 cycles", pop_count);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (pop_count !== 8'd0) begin
            n_fail++; $display("FAIL wrap_to_0: got %0d want 0", pop_count);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (pop_count !== 8'd1) begin
            n_fail++; $display("FAIL wrap_to_1: got %0d want 1", pop_count);
        end
        repeat (6) @(negedge clk);
        #1;
        n_tests++;
        if (valid_out !== 1'b0 || read !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_drained: got valid=%b read=%b want 0 0", valid_out, read);
        end
    endtask

    task automatic test_alternating_ready();
        int idx;
        idx = 0;
        for (int i = 0; i < 8; i++) push(8'h80 + 8'(i));
        for (int c = 0; c < 60 && idx < 8; c++) begin
            @(negedge clk);
            ready_in = (c % 2 == 0);
            #1;
            if (valid_out && ready_in) begin
                n_tests++;
                if (data_out !== 8'h80 + 8'(idx)) begin
                    n_fail++;
                    $display("FAIL alt_data[%0d]: got %h want %h", idx, data_out,
                             8'h80 + 8'(idx));
                end
                idx++;
            end
        end
        n_tests++;
        if (idx != 8) begin
            n_fail++; $display("FAIL alt_delivered: got %0d words want 8", idx);
        end
        n_tests++;
        if (pop_count !== 8'd9) begin
            n_fail++; $display("FAIL alt_pop_count: got %0d want 9", pop_count);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        ready_in = 1'b0;
        push(8'h31);
        push(8'h32);
        push(8'h33);
        push(8'h34);
        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if (valid_out !== 1'b1 || data_out !== 8'h31 || read !== 1'b0) begin
            n_fail++;
            $display("FAIL ar_buffered: got valid=%b data=%h read=%b want 1 31 0",
                     valid_out, data_out, read);
        end
        #2;
        reset = 1'b0;
        #1;
        n_tests++;
        if (valid_out !== 1'b0 || read !== 1'b0 || pop_count !== 8'd0 || data_out !== 8'h00) begin
            n_fail++;
            $display("FAIL ar_immediate: got valid=%b read=%b pop_count=%0d data=%h want 0 0 0 00",
                     valid_out, read, pop_count, data_out);
        end
        @(negedge clk);
        reset    = 1'b1;
        ready_in = 1'b1;
        #1;
        n_tests++;
        if (read !== 1'b0) begin
            n_fail++; $display("FAIL ar_idle_read: got %b want 0", read);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (read !== 1'b1) begin
            n_fail++; $display("FAIL ar_first_read: got %b want 1", read);
        end
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if (valid_out !== 1'b1 || data_out !== 8'h33) begin
            n_fail++;
            $display("FAIL ar_resume_data: got valid=%b data=%h want 1 33", valid_out, data_out);
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_error();
        test_counter_wrap();
        test_alternating_ready();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_pop_ctrl.md
# fifo_pop_ctrl

Read-side controller for the fifo_4x8 buffer in the PCIe switching datapath. It drives the FIFO `read` strobe, captures `data_out_pop` into a 2-entry holding buffer, and presents the words downstream with a valid/ready handshake. It stops reading on `fifo_error` and resumes only after an explicit clear. It also counts completed pops.

## Interface
- `DATA_SIZE`, default 8: FIFO word width.
- `CNT_SIZE`, default 8: width of the pop counter.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `fifo_empty`  in  1  FIFO empty flag, registered in the FIFO.
- `fifo_error`  in  1  FIFO error flag.
- `data_out_pop`  in  DATA_SIZE  FIFO read data.
- `read`  out  1  pop request to the FIFO.
- `ready_in`  in  1  downstream can accept a word.
- `valid_out`  out  1  `data_out` holds a valid word.
- `data_out`  out  DATA_SIZE  head word of the holding buffer.
- `clear_err`  in  1  request to leave the error state.
- `err_latched`  out  1  high while in state ERR.
- `pop_count`  out  CNT_SIZE  number of accepted FIFO pops; wraps.

## Operation
- FIFO read contract:
  - A pop is accepted when `read`=1 and `fifo_empty`=0 in cycle N.
  - `data_out_pop` is valid during cycle N+1 and is captured at the edge that ends N+1.
  - `read` while `fifo_empty`=1 is never issued.
- The controller keeps an `inflight` flag (a pop is awaiting capture) and a 2-entry circular buffer:
  - 1-bit write pointer and 1-bit read pointer.
  - 2-bit `count` in the range 0..2.
- `xfer` = `valid_out` & `ready_in`.
- `read` = (state==RUN) & !`fifo_empty` & (`count` + `inflight` − `xfer` < 2).
  - `read` is combinational; `ready_in` → `read` is a permitted path.
- `valid_out` = (`count` != 0).
- `data_out` = buf[rd_ptr]; it holds its value when `count`=0.
- Capture and transfer in the same cycle: `count` is unchanged and both pointers advance.
- `count` never exceeds 2. Capture into a full buffer is impossible by construction; the bench asserts on it.
- `pop_count` increments on each accepted pop and wraps from 2^CNT_SIZE−1 to 0.
- State machine:
  - IDLE → RUN: unconditionally, on the first edge after reset deasserts.
  - RUN → ERR: `fifo_error` sampled high. The error takes priority over a same-cycle `read`; `read` is 0 in that cycle.
  - ERR → RUN: `clear_err`=1 & `count`=0 & `inflight`=0. Otherwise `clear_err` is ignored.
  - ERR behaviour: `read`=0, any in-flight word is still captured, and the buffer keeps draining downstream.
- `err_latched` = (state==ERR).

## Timing
- Reset values: `read`=0, `valid_out`=0, `data_out`=0, `err_latched`=0, `pop_count`=0, state IDLE, buffer empty, `inflight`=0.
- First possible `read` is the first cycle in RUN, which is the 2nd cycle after `reset` rises.
- Latency from `read` (cycle N) to `valid_out` is 2: the word is visible in cycle N+2.
- Throughput with `ready_in`=1 and a non-empty FIFO is 1 word per cycle.
- With `ready_in`=0:
  - At most 2 words are buffered plus none in flight.
  - `read` drops once `count` + `inflight` = 2.
  - `read` re-asserts combinationally in the same cycle `ready_in` rises.
- `fifo_empty` rising stops `read` in the same cycle; no bubble accounting is needed.
- Reset asserted mid-operation: immediately returns all outputs to reset values. Buffered and in-flight words are discarded.

## Test plan
- Streaming: FIFO preloaded with 0xA1,0xB2,0xC3,0xD4 and `ready_in`=1 → `read` high 4 consecutive cycles, `data_out` shows the same sequence on 4 consecutive cycles starting 2 cycles after the first `read`, `pop_count`=4, `read` low once `fifo_empty`=1.
- Backpressure: 4 words, `ready_in`=0 for 6 cycles then 1 → exactly 2 pops before stall, `valid_out`=1 holding 0xA1, remaining 2 pops resume the cycle `ready_in` rises, order preserved, no loss or duplication.
- Error: `fifo_error` pulsed while a pop is in flight → `err_latched`=1 next cycle, `read` stays 0, the in-flight word still appears on `data_out`. `clear_err` before the buffer drains is ignored; `clear_err` after it drains → RUN and reads resume.
- Counter wrap: 257 pops with CNT_SIZE=8 → `pop_count` goes 255→0→1.
- Async reset mid-burst: assert `reset` between edges with 2 words buffered → `valid_out`, `read`, `pop_count` go to 0 immediately, and the first `read` after release comes 2 cycles after `reset` rises.
- Alternating `ready_in` (1,0,1,0…) with 8 words → `count` never exceeds 2, all 8 words delivered in order.
